// File: rtl/piece_motion_scheduler.sv
// Frame-synchronous motion sequencer for the falling piece: merges button and gravity
// requests, arbitrates them once per frame and updates the X/Y offsets.
module piece_motion_scheduler #(
    parameter int unsigned STEP           = 32,
    parameter int unsigned X_MIN          = 0,
    parameter int unsigned X_MAX          = 128,
    parameter int unsigned Y_MAX          = 320,
    parameter int unsigned SPAWN_X        = 64,
    parameter int unsigned GRAVITY_FRAMES = 30,
    parameter int unsigned REPEAT_FRAMES  = 8,
    parameter int unsigned LAND_FRAMES    = 60
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iFrameStart,
    input  logic       iPause,
    input  logic       iBtnLeft,
    input  logic       iBtnRight,
    input  logic       iBtnDown,
    output logic [9:0] oXOffset,
    output logic [9:0] oYOffset,
    output logic       oUpdate,
    output logic       oLanded
);
    localparam int unsigned GW = $clog2(GRAVITY_FRAMES + 1);
    localparam int unsigned RW = $clog2(REPEAT_FRAMES + 1);
    localparam int unsigned LW = $clog2(LAND_FRAMES + 1);

    typedef enum logic [1:0] {S_RUN, S_APPLY, S_LANDED, S_RESPAWN} state_t;

    state_t          state_q, state_d;
    logic [9:0]      x_q, x_d, y_q, y_d;
    logic            upd_q, upd_d;
    logic [2:0]      btn_prev_q, btn_prev_d;
    logic [2:0]      pend_q, pend_d;
    logic            grav_req_q, grav_req_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic [LW-1:0]   lcnt_q, lcnt_d;
    logic [RW-1:0]   hold_q [3];
    logic [RW-1:0]   hold_d [3];

    logic [2:0]      btns, new_req;
    logic            accept, pulse, grav_new;
    logic [10:0]     x_ext, y_ext;

    // Bit order of all per-button vectors: 0 = left, 1 = right, 2 = down.
    assign btns   = {iBtnDown, iBtnRight, iBtnLeft};
    assign accept = !iPause && (state_q != S_LANDED);
    assign pulse  = iFrameStart && !iPause;
    assign x_ext  = {1'b0, x_q};
    assign y_ext  = {1'b0, y_q};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= S_RUN;
            x_q        <= 10'(SPAWN_X);
            y_q        <= '0;
            upd_q      <= 1'b0;
            btn_prev_q <= '0;
            pend_q     <= '0;
            grav_req_q <= 1'b0;
            gcnt_q     <= '0;
            lcnt_q     <= '0;
            hold_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            upd_q      <= upd_d;
            btn_prev_q <= btn_prev_d;
            pend_q     <= pend_d;
            grav_req_q <= grav_req_d;
            gcnt_q     <= gcnt_d;
            lcnt_q     <= lcnt_d;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        upd_d      = 1'b0;
        btn_prev_d = btns;
        gcnt_d     = gcnt_q;
        lcnt_d     = lcnt_q;
        hold_d     = hold_q;
        new_req    = '0;
        grav_new   = 1'b0;

        for (int unsigned i = 0; i < 3; i++) begin
            if (!btns[i]) begin
                hold_d[i] = '0;
            end else if (accept && iFrameStart) begin
                if (hold_q[i] == RW'(REPEAT_FRAMES - 1)) begin
                    hold_d[i]  = '0;
                    new_req[i] = 1'b1;
                end else begin
                    hold_d[i] = hold_q[i] + 1'b1;
                end
            end
            if (accept && btns[i] && !btn_prev_q[i]) new_req[i] = 1'b1;
        end

        if (state_q == S_RUN && pulse) begin
            if (gcnt_q == GW'(GRAVITY_FRAMES - 1)) begin
                gcnt_d   = '0;
                grav_new = 1'b1;
            end else begin
                gcnt_d = gcnt_q + 1'b1;
            end
        end

        pend_d     = pend_q | new_req;
        grav_req_d = grav_req_q | grav_new;

        unique case (state_q)
            S_RUN: begin
                if (pulse) state_d = S_APPLY;
            end
            S_APPLY: begin
                state_d = S_RUN;
                if (pend_q[0] ^ pend_q[1]) begin
                    if (pend_q[0]) begin
                        if (x_ext >= 11'(X_MIN + STEP)) x_d = x_q - 10'(STEP);
                    end else if (x_ext + 11'(STEP) <= 11'(X_MAX)) begin
                        x_d = x_q + 10'(STEP);
                    end
                end
                if (pend_q[2] || grav_req_q) begin
                    if (y_ext + 11'(STEP) <= 11'(Y_MAX)) begin
                        y_d = y_q + 10'(STEP);
                        if (pend_q[2]) gcnt_d = '0;
                    end else begin
                        state_d = S_LANDED;
                    end
                end
                upd_d      = (x_d != x_q) || (y_d != y_q);
                // Requests raised during this very cycle survive into the next frame.
                pend_d     = new_req;
                grav_req_d = 1'b0;
            end
            S_LANDED: begin
                if (pulse) begin
                    if (lcnt_q == LW'(LAND_FRAMES - 1)) begin
                        lcnt_d  = '0;
                        state_d = S_RESPAWN;
                    end else begin
                        lcnt_d = lcnt_q + 1'b1;
                    end
                end
            end
            S_RESPAWN: begin
                state_d    = S_RUN;
                x_d        = 10'(SPAWN_X);
                y_d        = '0;
                upd_d      = 1'b1;
                pend_d     = '0;
                grav_req_d = 1'b0;
                gcnt_d     = '0;
                lcnt_d     = '0;
                hold_d     = '{default: '0};
            end
            default: state_d = S_RUN;
        endcase
    end

    assign oXOffset = x_q;
    assign oYOffset = y_q;
    assign oUpdate  = upd_q;
    assign oLanded  = (state_q == S_LANDED);
endmodule
